// File: rtl/addr_past_checker.sv
// Multi-channel busy |=> $past(addr,L) == addr stability monitor.
// Per-channel history, pass/fail pulses, saturating counters, first-fail capture.
module addr_past_checker #(
  parameter int ADDR_W = 32,
  parameter int NCH    = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [NCH-1:0]        busy_i,
  input  logic [NCH*ADDR_W-1:0] addr_i,
  input  logic                  chk_en_i,
  input  logic [LW-1:0]         cfg_lag_i,
  input  logic                  err_clr_i,
  output logic [NCH-1:0]        pass_o,
  output logic [NCH-1:0]        fail_o,
  output logic                  err_o,
  output logic [NCH*CNT_W-1:0]  viol_cnt_o,
  output logic                  first_vld_o,
  output logic [CHW-1:0]        first_ch_o,
  output logic [ADDR_W-1:0]     first_addr_o,
  output logic [ADDR_W-1:0]     first_exp_o
);

  localparam logic [LW-1:0]    DMAX = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;

  // index k holds the sample taken k+1 cycles ago
  logic [ADDR_W-1:0] addr_hist [NCH][DEPTH];
  logic              busy_hist [NCH][DEPTH];
  logic [LW-1:0]     fill;
  logic [LW-1:0]     lag;
  logic [CNT_W-1:0]  cnt [NCH];

  logic [ADDR_W-1:0] cur   [NCH];
  logic [ADDR_W-1:0] exp_a [NCH];
  logic [NCH-1:0]    busy_sel;
  logic [NCH-1:0]    act;
  logic [NCH-1:0]    pass_d;
  logic [NCH-1:0]    fail_d;
  logic [CHW-1:0]    f_ch;
  logic [ADDR_W-1:0] f_addr;
  logic [ADDR_W-1:0] f_exp;

  always_comb begin
    lag = cfg_lag_i;
    if (cfg_lag_i == '0)
      lag = LW'(1);
    else if (cfg_lag_i > DMAX)
      lag = DMAX;
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cur[c]      = addr_i[c*ADDR_W +: ADDR_W];
      exp_a[c]    = '0;
      busy_sel[c] = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (lag == LW'(k + 1)) begin
          exp_a[c]    = addr_hist[c][k];
          busy_sel[c] = busy_hist[c][k];
        end
      end
      act[c]    = chk_en_i && (fill >= lag) && busy_sel[c];
      pass_d[c] = act[c] && (cur[c] == exp_a[c]);
      fail_d[c] = act[c] && (cur[c] != exp_a[c]);
    end
  end

  // descending scan so the lowest failing channel is the last assignment
  always_comb begin
    f_ch   = '0;
    f_addr = '0;
    f_exp  = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (fail_d[c]) begin
        f_ch   = CHW'(c);
        f_addr = cur[c];
        f_exp  = exp_a[c];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      fill         <= '0;
      pass_o       <= '0;
      fail_o       <= '0;
      err_o        <= 1'b0;
      first_vld_o  <= 1'b0;
      first_ch_o   <= '0;
      first_addr_o <= '0;
      first_exp_o  <= '0;
      for (int c = 0; c < NCH; c++) begin
        cnt[c] <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          addr_hist[c][k] <= '0;
          busy_hist[c][k] <= 1'b0;
        end
      end
    end else begin
      if (fill != DMAX)
        fill <= fill + LW'(1);
      pass_o <= pass_d;
      fail_o <= fail_d;
      for (int c = 0; c < NCH; c++) begin
        addr_hist[c][0] <= cur[c];
        busy_hist[c][0] <= busy_i[c];
        for (int k = DEPTH - 1; k >= 1; k--) begin
          addr_hist[c][k] <= addr_hist[c][k-1];
          busy_hist[c][k] <= busy_hist[c][k-1];
        end
        if (err_clr_i)
          cnt[c] <= fail_d[c] ? CNT_W'(1) : '0;
        else if (fail_d[c] && cnt[c] != CMAX)
          cnt[c] <= cnt[c] + CNT_W'(1);
      end
      if (|fail_d)
        err_o <= 1'b1;
      else if (err_clr_i)
        err_o <= 1'b0;
      if (|fail_d && (!first_vld_o || err_clr_i)) begin
        first_vld_o  <= 1'b1;
        first_ch_o   <= f_ch;
        first_addr_o <= f_addr;
        first_exp_o  <= f_exp;
      end else if (err_clr_i) begin
        first_vld_o  <= 1'b0;
        first_ch_o   <= '0;
        first_addr_o <= '0;
        first_exp_o  <= '0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign viol_cnt_o[g*CNT_W +: CNT_W] = cnt[g];
  end

endmodule

// File: tb/tb_addr_past_checker.sv
// Randomized bench for addr_past_checker against a queue-based
// model of the sample history.
module tb_addr_past_checker;
  localparam int AW    = 32;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int LW    = 4;
  localparam int CHW   = 2;
  localparam int CMAX  = 255;

  logic              hclk;
  logic              hresetn;
  logic [NCH-1:0]    busy_i;
  logic [NCH*AW-1:0] addr_i;
  logic              chk_en_i;
  logic [LW-1:0]     cfg_lag_i;
  logic              err_clr_i;
  logic [NCH-1:0]    pass_o;
  logic [NCH-1:0]    fail_o;
  logic              err_o;
  logic [NCH*CW-1:0] viol_cnt_o;
  logic              first_vld_o;
  logic [CHW-1:0]    first_ch_o;
  logic [AW-1:0]     first_addr_o;
  logic [AW-1:0]     first_exp_o;

  addr_past_checker #(
    .ADDR_W(AW), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .busy_i(busy_i), .addr_i(addr_i),
    .chk_en_i(chk_en_i), .cfg_lag_i(cfg_lag_i),
    .err_clr_i(err_clr_i),
    .pass_o(pass_o), .fail_o(fail_o), .err_o(err_o),
    .viol_cnt_o(viol_cnt_o),
    .first_vld_o(first_vld_o), .first_ch_o(first_ch_o),
    .first_addr_o(first_addr_o), .first_exp_o(first_exp_o)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [NCH-1:0]    busy;
    logic [NCH*AW-1:0] addr;
  } smp_t;

  smp_t           past[$];
  int             cnt[NCH];
  bit             m_err;
  bit             m_fvld;
  int             m_fch;
  logic [AW-1:0]  m_faddr;
  logic [AW-1:0]  m_fexp;
  logic [NCH-1:0] m_pass;
  logic [NCH-1:0] m_fail;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic clr_model();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    m_err   = 0;
    m_fvld  = 0;
    m_fch   = 0;
    m_faddr = '0;
    m_fexp  = '0;
  endtask

  task automatic model(bit rn, bit en, int lag, bit clr,
                       logic [NCH-1:0] b, logic [NCH*AW-1:0] a);
    int L;
    logic [AW-1:0] ac, ap;
    m_pass = '0;
    m_fail = '0;
    if (!rn) begin
      past.delete();
      clr_model();
      return;
    end
    L = (lag < 1) ? 1 : (lag > DEPTH) ? DEPTH : lag;
    for (int c = 0; c < NCH; c++) begin
      if (en && past.size() >= L && past[L-1].busy[c]) begin
        ac = a[c*AW +: AW];
        ap = past[L-1].addr[c*AW +: AW];
        if (ac == ap) m_pass[c] = 1'b1;
        else          m_fail[c] = 1'b1;
      end
    end
    if (clr) clr_model();
    for (int c = 0; c < NCH; c++) begin
      if (m_fail[c]) begin
        if (cnt[c] < CMAX) cnt[c]++;
        m_err = 1;
        if (!m_fvld) begin
          m_fvld  = 1;
          m_fch   = c;
          m_faddr = a[c*AW +: AW];
          m_fexp  = past[L-1].addr[c*AW +: AW];
        end
      end
    end
    past.push_front('{busy: b, addr: a});
    if (past.size() > DEPTH) void'(past.pop_back());
  endtask

  task automatic step(bit rn, bit en, int lag, bit clr,
                      logic [NCH-1:0] b, logic [NCH*AW-1:0] a);
    @(negedge hclk);
    hresetn   = rn;
    chk_en_i  = en;
    cfg_lag_i = LW'(lag);
    err_clr_i = clr;
    busy_i    = b;
    addr_i    = a;
    model(rn, en, lag, clr, b, a);
    @(posedge hclk);
    #1;
    chk("pass", pass_o, m_pass);
    chk("fail", fail_o, m_fail);
    chk("onehot", pass_o & fail_o, '0);
    chk("err", err_o, m_err);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("cnt%0d", c), viol_cnt_o[c*CW +: CW], cnt[c]);
    chk("fvld", first_vld_o, m_fvld);
    chk("fch", first_ch_o, m_fch);
    chk("faddr", first_addr_o, m_faddr);
    chk("fexp", first_exp_o, m_fexp);
  endtask

  function automatic logic [NCH*AW-1:0] rnd_addr(int span);
    logic [NCH*AW-1:0] a;
    for (int c = 0; c < NCH; c++) begin
      if ($urandom_range(0, 19) == 0)
        a[c*AW +: AW] = $urandom;
      else
        a[c*AW +: AW] = AW'($urandom_range(0, span));
    end
    return a;
  endfunction

  function automatic logic [NCH*AW-1:0] ch0(int v);
    logic [NCH*AW-1:0] a;
    a = '0;
    a[AW-1:0] = AW'(v);
    return a;
  endfunction

  initial begin
    int lag;
    bit en;
    hresetn   = 1'b0;
    chk_en_i  = 1'b0;
    cfg_lag_i = '0;
    err_clr_i = 1'b0;
    busy_i    = '0;
    addr_i    = '0;
    model(0, 0, 1, 0, '0, '0);

    repeat (3) step(0, 1, 1, 0, '0, '0);

    step(1, 1, 1, 0, 4'b0, ch0(5));
    step(1, 1, 1, 0, 4'b0, ch0(8));
    step(1, 1, 1, 0, 4'b0, ch0(10));
    step(1, 1, 1, 0, 4'b1, ch0(13));
    step(1, 1, 1, 0, 4'b0, ch0(13));
    step(1, 1, 1, 0, 4'b0, ch0(11));
    step(1, 1, 1, 0, 4'b1, ch0(13));
    step(1, 1, 1, 0, 4'b0, ch0(14));

    step(0, 1, 4, 0, '0, '0);
    step(1, 1, 4, 0, 4'b1111, rnd_addr(1));
    repeat (6) step(1, 1, 4, 0, 4'($urandom), rnd_addr(1));

    lag = 3;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) lag = $urandom_range(0, 15);
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) != 0,
           lag,
           $urandom_range(0, 29) == 0,
           4'($urandom), rnd_addr(3));
    end

    for (int i = 0; i < 700; i++)
      step(1, 1, 1, 0, 4'b1111, rnd_addr(1));
    step(1, 1, 1, 1, 4'b1111, rnd_addr(1));

    en = 1;
    lag = 2;
    for (int i = 0; i < 400; i++) begin
      if (i % 5 == 0) en = $urandom_range(0, 1);
      if (i % 50 == 0) lag = $urandom_range(1, DEPTH + 2);
      step(1, en, lag, $urandom_range(0, 39) == 0,
           4'($urandom), rnd_addr(2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
